// File: rtl/split_bus_arbiter_if.sv
// Bus handshake bundle between requesting masters, the split-capable slave
// and the arbiter. The arbiter sits on the slave modport; the traffic source
// (masters plus slave split signalling) sits on the master modport.
interface split_bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_WIDTH   = 2
);
  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [NUM_MASTERS-1:0] msplit;
  logic                   ssplit;
  logic                   split_done;
  logic [IDX_WIDTH-1:0]   owner;
  logic                   bus_busy;

  modport slave (
    input  breq, ssplit, split_done,
    output bgrant, msplit, owner, bus_busy
  );

  modport master (
    output breq, ssplit, split_done,
    input  bgrant, msplit, owner, bus_busy
  );
endinterface

// File: rtl/split_bus_arbiter.sv
// Round-robin bus arbiter with split-transaction support. One master owns the
// bus at a time; a slave may suspend the owner (split), which removes it from
// arbitration until the slave signals split_done, after which that master is
// given priority on its next request. At most one split is outstanding.
module split_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_WIDTH   = 2
) (
  input  logic clk,
  input  logic rstn,
  split_bus_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_reg;
  logic [NUM_MASTERS-1:0] bgrant_reg;
  logic [NUM_MASTERS-1:0] msplit_reg;
  logic [NUM_MASTERS-1:0] resume_reg;
  logic [IDX_WIDTH-1:0]   owner_reg;
  logic [IDX_WIDTH-1:0]   last_owner_reg;
  logic [IDX_WIDTH-1:0]   split_idx_reg;
  logic                   busy_reg;
  logic                   split_out_reg;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] resume_cand;
  logic [NUM_MASTERS-1:0] cand;
  logic [IDX_WIDTH:0]     rr_idx;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_valid;
  logic                   done_ok;
  logic                   split_blocked;

  // A suspended master cannot compete; a resumed one that requests is favoured.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
    assign elig[gi]        = bus.breq[gi] & ~msplit_reg[gi];
    assign resume_cand[gi] = elig[gi] & resume_reg[gi];
  end

  // split_done frees the split slot in the same cycle a new ssplit may claim it.
  assign done_ok       = bus.split_done & split_out_reg;
  assign split_blocked = split_out_reg & ~bus.split_done;

  // Pick the first candidate scanning upward from last_owner+1, wrapping at NUM_MASTERS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    rr_idx     = '0;
    cand       = (|resume_cand) ? resume_cand : elig;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_idx = {1'b0, last_owner_reg} + (IDX_WIDTH+1)'(k);
      if (rr_idx >= (IDX_WIDTH+1)'(NUM_MASTERS))
        rr_idx = rr_idx - (IDX_WIDTH+1)'(NUM_MASTERS);
      if (!pick_valid && cand[rr_idx[IDX_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_idx[IDX_WIDTH-1:0];
      end
    end
  end

  // Ownership FSM with registered grant, split and resume bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      bgrant_reg     <= '0;
      msplit_reg     <= '0;
      resume_reg     <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_WIDTH'(NUM_MASTERS - 1);
      split_idx_reg  <= '0;
      busy_reg       <= 1'b0;
      split_out_reg  <= 1'b0;
    end else begin
      if (done_ok) begin
        msplit_reg[split_idx_reg] <= 1'b0;
        resume_reg[split_idx_reg] <= 1'b1;
        split_out_reg             <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            bgrant_reg           <= NUM_MASTERS'(1) << pick_idx;
            owner_reg            <= pick_idx;
            busy_reg             <= 1'b1;
            resume_reg[pick_idx] <= 1'b0;
            state_reg            <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ssplit && !split_blocked) begin
            // Suspend the owner; it cannot be the master being resumed.
            msplit_reg[owner_reg] <= 1'b1;
            split_idx_reg         <= owner_reg;
            split_out_reg         <= 1'b1;
            bgrant_reg            <= '0;
            busy_reg              <= 1'b0;
            last_owner_reg        <= owner_reg;
            state_reg             <= IDLE;
          end else if (!bus.breq[owner_reg]) begin
            bgrant_reg     <= '0;
            busy_reg       <= 1'b0;
            last_owner_reg <= owner_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.bgrant   = bgrant_reg;
  assign bus.msplit   = msplit_reg;
  assign bus.owner    = owner_reg;
  assign bus.bus_busy = busy_reg;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter: a directed vector table, a few
// hand-written corner sequences and a randomized run against a cycle model.
module tb_split_bus_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  split_bus_arbiter_if #(.NUM_MASTERS(N), .IDX_WIDTH(IW)) bus ();

  split_bus_arbiter #(.NUM_MASTERS(N), .IDX_WIDTH(IW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rstn;
    bit [2:0] breq;
    bit       ss;
    bit       sd;
    bit [2:0] g;
    bit [2:0] m;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit [2:0] b, bit ss, bit sd, bit [2:0] g, bit [2:0] m);
    vec_t v;
    v.rstn = r; v.breq = b; v.ss = ss; v.sd = sd; v.g = g; v.m = m;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against an expected grant vector and split vector.
  task automatic chk_out(string tag, bit [2:0] g, bit [2:0] m);
    chk({tag, ".bgrant"}, int'(bus.bgrant), int'(g));
    chk({tag, ".msplit"}, int'(bus.msplit), int'(m));
    chk({tag, ".bus_busy"}, int'(bus.bus_busy), int'(g != 3'b000));
    if (g != 3'b000) begin
      int oi = 0;
      for (int i = 0; i < N; i++) if (g[i]) oi = i;
      chk({tag, ".owner"}, int'(bus.owner), oi);
    end
  endtask

  // Apply one cycle of inputs, let the DUT clock it, then compare.
  task automatic step(string tag, bit r, bit [2:0] b, bit ss, bit sd, bit [2:0] g, bit [2:0] m);
    rstn = r; bus.breq = b; bus.ssplit = ss; bus.split_done = sd;
    @(posedge clk); #1;
    chk_out(tag, g, m);
    $display("%s rstn=%0b breq=%b ss=%0b sd=%0b -> bgrant=%b msplit=%b owner=%0d busy=%0b",
             tag, r, b, ss, sd, bus.bgrant, bus.msplit, bus.owner, bus.bus_busy);
  endtask

  // Behavioural reference: owner as an integer (-1 = idle), split as an index.
  int       m_owner, m_last, m_split;
  bit [2:0] m_msplit, m_resume;

  function automatic void model_reset();
    m_owner = -1; m_last = N - 1; m_split = -1; m_msplit = '0; m_resume = '0;
  endfunction

  function automatic void model_step(bit r, bit [2:0] b, bit ss, bit sd);
    int       n_owner, n_last, n_split;
    bit [2:0] n_msplit, n_resume;
    bit       done_ok;
    if (!r) begin
      model_reset();
      return;
    end
    n_owner = m_owner; n_last = m_last; n_split = m_split;
    n_msplit = m_msplit; n_resume = m_resume;
    done_ok = sd && (m_split >= 0);
    if (done_ok) begin
      n_msplit[m_split] = 1'b0;
      n_resume[m_split] = 1'b1;
      n_split = -1;
    end
    if (m_owner < 0) begin
      int winner = -1;
      // First pass only considers resumed masters, second pass everyone.
      for (int pass = 0; pass < 2 && winner < 0; pass++)
        for (int k = 1; k <= N; k++) begin
          int i = (m_last + k) % N;
          if (winner < 0 && b[i] && !m_msplit[i] && (pass == 1 || m_resume[i])) winner = i;
        end
      if (winner >= 0) begin
        n_owner = winner;
        n_resume[winner] = 1'b0;
      end
    end else begin
      if (ss && !(m_split >= 0 && !done_ok)) begin
        n_msplit[m_owner] = 1'b1;
        n_split = m_owner;
        n_last = m_owner;
        n_owner = -1;
      end else if (!b[m_owner]) begin
        n_last = m_owner;
        n_owner = -1;
      end
    end
    m_owner = n_owner; m_last = n_last; m_split = n_split;
    m_msplit = n_msplit; m_resume = n_resume;
  endfunction

  initial begin
    rstn = 1'b0; bus.breq = '0; bus.ssplit = 1'b0; bus.split_done = 1'b0;

    // Reset, three masters served in order, split / ignored split / combined pulses, reset.
    add(0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(0, 3'b111, 0, 0, 3'b000, 3'b000);
    add(1, 3'b111, 0, 0, 3'b001, 3'b000);
    add(1, 3'b111, 0, 0, 3'b001, 3'b000);
    add(1, 3'b111, 0, 0, 3'b001, 3'b000);
    add(1, 3'b111, 0, 0, 3'b001, 3'b000);
    add(1, 3'b110, 0, 0, 3'b000, 3'b000);
    add(1, 3'b110, 0, 0, 3'b010, 3'b000);
    add(1, 3'b110, 0, 0, 3'b010, 3'b000);
    add(1, 3'b110, 0, 0, 3'b010, 3'b000);
    add(1, 3'b110, 0, 0, 3'b010, 3'b000);
    add(1, 3'b100, 0, 0, 3'b000, 3'b000);
    add(1, 3'b100, 0, 0, 3'b100, 3'b000);
    add(1, 3'b100, 0, 0, 3'b100, 3'b000);
    add(1, 3'b100, 0, 0, 3'b100, 3'b000);
    add(1, 3'b100, 0, 0, 3'b100, 3'b000);
    add(1, 3'b000, 0, 0, 3'b000, 3'b000);
    add(1, 3'b000, 0, 0, 3'b000, 3'b000);
    add(1, 3'b010, 0, 0, 3'b010, 3'b000);
    add(1, 3'b011, 1, 0, 3'b000, 3'b010);
    add(1, 3'b011, 0, 0, 3'b001, 3'b010);
    add(1, 3'b011, 0, 0, 3'b001, 3'b010);
    add(1, 3'b011, 1, 0, 3'b001, 3'b010);
    add(1, 3'b011, 1, 1, 3'b000, 3'b001);
    add(1, 3'b011, 0, 0, 3'b010, 3'b001);
    add(1, 3'b011, 0, 0, 3'b010, 3'b001);
    add(0, 3'b011, 0, 0, 3'b000, 3'b000);
    add(1, 3'b010, 0, 0, 3'b010, 3'b000);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].breq, tbl[i].ss, tbl[i].sd, tbl[i].g, tbl[i].m);

    // Resumed master 1 beats round-robin choice of master 0 after master 2 releases.
    step("res1", 1, 3'b010, 1, 0, 3'b000, 3'b010);
    step("res2", 1, 3'b100, 0, 0, 3'b100, 3'b010);
    step("res3", 1, 3'b111, 0, 1, 3'b100, 3'b000);
    step("res4", 1, 3'b111, 0, 0, 3'b100, 3'b000);
    step("res5", 1, 3'b011, 0, 0, 3'b000, 3'b000);
    step("res6", 1, 3'b011, 0, 0, 3'b010, 3'b000);
    step("res7", 1, 3'b001, 0, 0, 3'b000, 3'b000);
    step("res8", 1, 3'b001, 0, 0, 3'b001, 3'b000);

    // split_done in the arbitration cycle: master eligible only one cycle later.
    step("late1", 1, 3'b001, 1, 0, 3'b000, 3'b001);
    step("late2", 1, 3'b001, 0, 1, 3'b000, 3'b000);
    step("late3", 1, 3'b001, 0, 0, 3'b001, 3'b000);

    // Reset in BUSY while master 1 is suspended, then a one-cycle grant.
    step("rst1", 1, 3'b011, 0, 0, 3'b001, 3'b000);
    step("rst2", 1, 3'b000, 0, 0, 3'b000, 3'b000);
    step("rst3", 1, 3'b010, 0, 0, 3'b010, 3'b000);
    step("rst4", 1, 3'b011, 1, 0, 3'b000, 3'b010);
    step("rst5", 1, 3'b101, 0, 0, 3'b100, 3'b010);
    step("rst6", 0, 3'b101, 0, 0, 3'b000, 3'b000);
    step("rst7", 1, 3'b010, 0, 0, 3'b010, 3'b000);

    // Randomized traffic against the reference model.
    rstn = 1'b0; bus.breq = '0; bus.ssplit = 1'b0; bus.split_done = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit       r  = ($urandom_range(0, 99) >= 2);
      bit [2:0] b  = 3'($urandom_range(0, 7));
      bit       ss = ($urandom_range(0, 99) < 15);
      bit       sd = ($urandom_range(0, 99) < 15);
      bit [2:0] eg;
      model_step(r, b, ss, sd);
      eg = (m_owner >= 0) ? 3'(3'b001 << m_owner) : 3'b000;
      step($sformatf("rnd%0d", c), r, b, ss, sd, eg, m_msplit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/split_bus_arbiter.md
SPLIT_BUS_ARBITER -- requirements
Module: split_bus_arbiter

Interface
REQ-001 Parameter: NUM_MASTERS, default 3, number of requesting master ports (2..8).
REQ-002 Parameter: IDX_WIDTH, default 2, width of owner index; SHALL satisfy 2**IDX_WIDTH >= NUM_MASTERS.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 breq  input  NUM_MASTERS  per-master bus request, level, held for whole transaction.
REQ-006 bgrant  output  NUM_MASTERS  registered one-hot grant; all-zero when bus idle.
REQ-007 msplit  output  NUM_MASTERS  registered; bit i high while master i is suspended by a split.
REQ-008 ssplit  input  1  slave split pulse, one cycle, applies to current owner.
REQ-009 split_done  input  1  slave ready to resume the split transaction, one-cycle pulse.
REQ-010 owner  output  IDX_WIDTH  index of granted master; valid only when bus_busy=1.
REQ-011 bus_busy  output  1  high while any bgrant bit is high.

Function
REQ-012 The block SHALL implement FSM states IDLE and BUSY.
REQ-013 IDLE: if any eligible master requests, grant it next cycle (bgrant bit, owner, bus_busy set); state -> BUSY; latency request-to-grant = 1 cycle.
REQ-014 Eligible: breq[i]=1 and msplit[i]=0.
REQ-015 Priority: a resumed split master (resume flag set, its breq high) SHALL win; otherwise round-robin starting at (last_owner+1) mod NUM_MASTERS.
REQ-016 The resume flag SHALL clear when that master is granted; if its breq is low at arbitration, flag persists and round-robin proceeds.
REQ-017 BUSY: grant held while breq[owner]=1, regardless of other requests (no preemption).
REQ-018 BUSY and breq[owner]=0: next cycle bgrant=0, bus_busy=0, state -> IDLE, last_owner=owner; a new grant occurs no earlier than the following cycle (one dead cycle between owners).
REQ-019 BUSY and ssplit=1 with no split outstanding: next cycle msplit[owner]=1, split index recorded, bgrant=0, state -> IDLE, last_owner=owner.
REQ-020 ssplit while a split is already outstanding SHALL be ignored (grant unchanged); ssplit in IDLE SHALL be ignored.
REQ-021 split_done with a split outstanding: next cycle clear msplit[split index], set resume flag for that master.
REQ-022 split_done with no split outstanding SHALL be ignored.
REQ-023 split_done and ssplit in the same cycle: split_done clears the old split and the new ssplit is then captured (both honoured); the new split master is the current owner.
REQ-024 split_done arriving in the same cycle the suspended master would arbitrate: master not eligible that cycle; eligible from next cycle.
REQ-025 At most one bgrant bit SHALL be high in any cycle; owner SHALL equal the index of that bit.
REQ-026 Index arithmetic SHALL wrap modulo NUM_MASTERS, not 2**IDX_WIDTH.

Reset
REQ-027 With rstn=0 at a clock edge: state IDLE, bgrant=0, msplit=0, owner=0, bus_busy=0, last_owner=NUM_MASTERS-1, resume flags and split record cleared.
REQ-028 Reset mid-transaction or mid-split SHALL abandon all ownership and split records immediately; first grant possible on the cycle after rstn returns high.

Verification
REQ-029 breq=3'b111 from reset, each master holds 4 cycles then drops -> grants in order 001,010,100 with one all-zero cycle between each.
REQ-030 Master 1 granted, ssplit pulse -> next cycle bgrant=000, msplit=010; master 0 requesting gets grant 001 one cycle later; master 1 request ignored.
REQ-031 Split on master 1 outstanding, master 2 busy, split_done pulse, masters 0 and 1 requesting -> msplit=000; after master 2 releases, grant 010 before 001.
REQ-032 Second ssplit while master 1 split outstanding -> ignored, current owner keeps grant, msplit unchanged.
REQ-033 split_done and ssplit same cycle (master 1 split, master 0 owner) -> msplit goes 010 -> 001, bgrant=000 next cycle.
REQ-034 rstn low during BUSY with msplit=010 -> next cycle all outputs zero; after release, breq=010 -> grant 010 in 1 cycle.
